// File: rtl/srl_fifo.sv
// Valid/ready FIFO on a reset-free, enable-gated shift register read through a dynamic address (SRL-mappable).
// Define SRL_FIFO_OREG_EN to add a registered output stage (capacity DEPTH+1, 2-cycle first-word latency).
module srl_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rn,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_srl_q, count_srl_d;
    logic             push;
    logic             pop;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    assign in_ready = (count_srl_q != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign rd_addr  = AW'(count_srl_q - CW'(1));
    assign rd_data  = mem_q[rd_addr];

    // Storage: no reset and a single enable, so each bit column maps to one SRL.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[0] <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

`ifdef SRL_FIFO_OREG_EN
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             load;

    // Output stage refills from the SRL whenever it is empty or being drained.
    always_comb begin
        pop         = vld_q & out_ready;
        load        = (count_srl_q != '0) & (~vld_q | out_ready);
        vld_d       = vld_q;
        out_d       = out_q;
        count_srl_d = count_srl_q;
        if (load) begin
            vld_d = 1'b1;
            out_d = rd_data;
        end else if (pop) begin
            vld_d = 1'b0;
            out_d = '0;
        end
        if (push && !load) begin
            count_srl_d = count_srl_q + CW'(1);
        end else if (load && !push) begin
            count_srl_d = count_srl_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            count_srl_q <= '0;
            vld_q       <= 1'b0;
            out_q       <= '0;
        end else begin
            count_srl_q <= count_srl_d;
            vld_q       <= vld_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = out_q;
    assign count     = count_srl_q + CW'(vld_q);
`else
    // Fall-through: the oldest entry always sits at address count-1.
    always_comb begin
        pop         = out_valid & out_ready;
        count_srl_d = count_srl_q;
        if (push && !pop) begin
            count_srl_d = count_srl_q + CW'(1);
        end else if (pop && !push) begin
            count_srl_d = count_srl_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            count_srl_q <= '0;
        end else begin
            count_srl_q <= count_srl_d;
        end
    end

    assign out_valid = (count_srl_q != '0);
    assign out_data  = out_valid ? rd_data : '0;
    assign count     = count_srl_q;
`endif

endmodule

// File: tb/tb_srl_fifo.sv
// Randomized and directed bench for srl_fifo against a queue-based reference model.
module tb_srl_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = $clog2(D) + 1;
`ifdef SRL_FIFO_OREG_EN
    localparam int unsigned CAP = D + 1;
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned CAP = D;
    localparam int unsigned LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rn;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    int max_cnt = 0;

    // Reference model: words waiting in order, plus the output slot when registered.
    logic [W-1:0] q[$];
    logic         m_ovld;
    logic [W-1:0] m_odata;

    srl_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rn        (rn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovld  = 1'b0;
        m_odata = '0;
    endtask

    task automatic model_check();
        int           m_cnt;
        logic         m_vld;
        logic [W-1:0] m_dat;
`ifdef SRL_FIFO_OREG_EN
        m_cnt = q.size() + int'(m_ovld);
        m_vld = m_ovld;
        m_dat = m_ovld ? m_odata : '0;
`else
        m_cnt = q.size();
        m_vld = (m_cnt != 0);
        m_dat = m_vld ? q[0] : '0;
`endif
        chk("count", 64'(count), 64'(m_cnt));
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        chk("out_data", 64'(out_data), 64'(m_dat));
        chk("in_ready", 64'(in_ready), 64'(q.size() != D));
    endtask

    task automatic model_step(input logic iv, input logic [W-1:0] d, input logic ordy);
        bit do_push;
        do_push = iv && (q.size() != D);
`ifdef SRL_FIFO_OREG_EN
        if (q.size() != 0 && (!m_ovld || ordy)) begin
            m_odata = q.pop_front();
            m_ovld  = 1'b1;
        end else if (m_ovld && ordy) begin
            m_ovld  = 1'b0;
        end
`else
        if (q.size() != 0 && ordy) begin
            void'(q.pop_front());
        end
`endif
        if (do_push) q.push_back(d);
    endtask

    // One clock: drive, compare at the falling edge, advance model, settle past the rising edge.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        model_check();
        if (int'(count) > max_cnt) max_cnt = int'(count);
        model_step(iv, d, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * int'(CAP) + 4 && count != '0; k++) cycle(1'b0, '0, 1'b1);
        chk("drain_empty", 64'(count), 64'(0));
    endtask

    initial begin
        rn        = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b0;
        model_reset();

        // Reset held with a write request pending
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_count", 64'(count), 64'(0));
            chk("rst_vld", 64'(out_valid), 64'(0));
            chk("rst_irdy", 64'(in_ready), 64'(1));
            chk("rst_data", 64'(out_data), 64'(0));
            @(posedge clk);
            #1;
        end
        rn = 1'b1;

        cycle(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k < int'(LAT); k++) cycle(1'b0, '0, 1'b0);
        chk("first_vld", 64'(out_valid), 64'(1));
        chk("first_data", 64'(out_data), 64'hA5);
        drain();

        // Fill to capacity, refused overflow, ordered drain
        for (int i = 0; i < int'(CAP); i++) cycle(1'b1, W'(i + 1), 1'b0);
        chk("fill_count", 64'(count), 64'(CAP));
        chk("fill_irdy", 64'(in_ready), 64'(0));
        cycle(1'b1, 8'hFF, 1'b0);
        chk("refuse_count", 64'(count), 64'(CAP));
        for (int i = 0; i < int'(CAP); i++) begin
            chk("drain_seq", 64'(out_data), 64'(i + 1));
            cycle(1'b0, '0, 1'b1);
        end
        chk("drain_count", 64'(count), 64'(0));
        chk("drain_vld", 64'(out_valid), 64'(0));

        // Steady push and pop at occupancy 5
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("sim_count", 64'(count), 64'(5));
            chk("sim_seq", 64'(out_data), 64'(i));
            cycle(1'b1, W'(i + 5), 1'b1);
        end
        drain();

        // Full with a pop: write refused, occupancy drops by one
        for (int i = 0; i < int'(CAP); i++) cycle(1'b1, W'(8'h40 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        chk("fullpop_count", 64'(count), 64'(CAP - 1));
        chk("fullpop_irdy", 64'(in_ready), 64'(1));
        chk("fullpop_head", 64'(out_data), 64'h41);
        drain();

        // Asynchronous reset between edges
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(8'h20 + i), 1'b0);
        chk("pre_rst_count", 64'(count), 64'(9));
        in_valid = 1'b0;
        @(negedge clk);
        #1 rn = 1'b0;
        #1;
        chk("arst_vld", 64'(out_valid), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_data", 64'(out_data), 64'(0));
        model_reset();
        #1 rn = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h3C, 1'b0);
        for (int k = 1; k < int'(LAT); k++) cycle(1'b0, '0, 1'b0);
        chk("post_rst_data", 64'(out_data), 64'h3C);
        drain();

        // Random stress
        max_cnt = 0;
        for (int i = 0; i < 3 * int'(D) * 8; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0 ? 1 : 0));
        end
        chk("max_count_bound", 64'(max_cnt <= int'(CAP)), 64'(1));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
